alu_cmd_ctrl: RTL
=================

// Module: alu_cmd_ctrl
// PURPOSE
//  Command-side controller for the registered ALU: the requester for the ALU responder.
//  - Collects a 3-byte command frame from the byte receive stream.
//  - Issues one ALU operation and captures the registered result.
//  - Returns the result as two bytes, low byte first, on a valid/ready transmit interface.
//  - Sits between the RX byte path and the TX byte path of the system controller.
// PARAMETERS
//  DATA_WIDTH   8                  operand and byte width
//  OUT_WIDTH    2*DATA_WIDTH (16)  ALU result width, always 2 bytes
//  RES_TIMEOUT  8                  max cycles spent in WAIT_RES waiting for OUT_VALID
// PORTS
//  CLK        in   1    single system clock; all logic on posedge
//  RST        in   1    synchronous, active-high reset
//  RX_DATA    in   8    received byte
//  RX_VALID   in   1    1-cycle strobe; RX_DATA valid
//  ALU_OUT    in   16   ALU registered result
//  OUT_VALID  in   1    ALU result valid (one cycle after ALU_EN)
//  ALU_EN     out  1    ALU enable, exactly 1 cycle per command
//  ALU_FUN    out  4    ALU function code
//  A          out  8    operand A
//  B          out  8    operand B
//  TX_DATA    out  8    result byte to transmitter
//  TX_VALID   out  1    TX_DATA valid; held until accepted
//  TX_READY   in   1    transmitter accepts when TX_VALID & TX_READY
//  CMD_ERR    out  1    1-cycle pulse: bad header or result timeout
//  RX_DROP    out  1    1-cycle pulse: RX byte ignored while busy
// BEHAVIOUR
//  Reset: all outputs 0, internal result reg 0, state IDLE. Reset wins over any event.
//   Reset mid-operation aborts the command: no TX bytes and no error pulse afterwards.
//  Frame format: byte0 = {4'hC, FUN}, byte1 = A, byte2 = B.
//  FSM transitions:
//  - IDLE -> GET_A: on RX_VALID with RX_DATA[7:4]==4'hC; latch ALU_FUN = RX_DATA[3:0].
//   Other header values: CMD_ERR pulse next cycle, stay IDLE.
//  - GET_A -> GET_B: on RX_VALID; latch A.
//  - GET_B -> ISSUE: on RX_VALID; latch B.
//  - ISSUE -> WAIT_RES: ISSUE lasts 1 cycle with ALU_EN=1. ALU_EN=0 in every other state.
//  - WAIT_RES -> SEND_LO: on OUT_VALID=1; result reg <= ALU_OUT.
//  - WAIT_RES -> IDLE: on RES_TIMEOUT cycles without OUT_VALID; pulse CMD_ERR.
//  - SEND_LO -> SEND_HI: TX_VALID=1, TX_DATA=res[7:0]; advance on TX_READY.
//  - SEND_HI -> IDLE: TX_VALID=1, TX_DATA=res[15:8]; advance on TX_READY.
//  Operand and transmit hold rules:
//  - A, B and ALU_FUN are registered and held stable from latch until the next frame overwrites them.
//  - TX_VALID is never deasserted and TX_DATA never changes before acceptance.
//  - TX_VALID is 0 for the cycle after SEND_HI is accepted: no back-to-back frames without IDLE.
//  Latency: RX_VALID of byte2 at cycle t -> ALU_EN at t+1 -> OUT_VALID at t+2 -> TX_VALID (lo) at t+3.
//  RX_VALID in ISSUE, WAIT_RES, SEND_LO or SEND_HI: byte dropped, RX_DROP pulse next cycle, FSM unaffected.
//  OUT_VALID outside WAIT_RES: ignored.
//  ALU_FUN 4'hF is passed through unchanged; the ALU returns 0, so the reply is 0x00,0x00.
//  No inter-byte timeout: a partial frame waits indefinitely in GET_A or GET_B.
// TESTING
//  1. Frame C0,12,34; ALU model answers 0x0046 -> ALU_EN 1 cycle with A=12,B=34,FUN=0; TX 0x46 then 0x00.
//  2. Frame C2,FF,FF, TX_READY low 3 cycles -> TX_VALID held with TX_DATA=0x01 stable; then 0x01,0xFE accepted.
//  3. Header 0x55, then frame CB,09,03 -> CMD_ERR pulse once, no ALU_EN for 0x55; second frame returns 0x02,0x00.
//  4. Frame C0,01,01 with OUT_VALID forced 0 -> CMD_ERR 8 cycles into WAIT_RES, no TX, back in IDLE.
//  5. Extra RX_VALID during WAIT_RES -> RX_DROP pulse, reply unchanged; next frame decodes correctly.
//  6. RST high in WAIT_RES -> all outputs 0 next cycle, no TX bytes; subsequent frame C1,10,01 returns 0x0F,0x00.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
//   Command-side controller for the registered ALU. It collects a 3-byte
//   command frame {4'hC,FUN}, A, B from the RX byte stream, issues a single
//   ALU operation, captures the registered result and returns it on the TX
//   byte interface, low byte first.
//
// Ports
//   CLK, RST             system clock, synchronous active-high reset
//   RX_DATA, RX_VALID    received byte and its 1-cycle strobe
//   ALU_OUT, OUT_VALID   registered ALU result and its valid flag
//   ALU_EN               1-cycle ALU enable per command
//   ALU_FUN, A, B        registered function code and operands
//   TX_DATA, TX_VALID    result byte, held until accepted
//   TX_READY             transmitter accept
//   CMD_ERR              1-cycle pulse: bad header or result timeout
//   RX_DROP              1-cycle pulse: RX byte ignored while busy
module alu_cmd_ctrl #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned OUT_WIDTH   = 2 * DATA_WIDTH,
   parameter int unsigned RES_TIMEOUT = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_DATA,
   input  logic                  RX_VALID,
   input  logic [OUT_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_VALID,
   output logic                  ALU_EN,
   output logic [3:0]            ALU_FUN,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] B,
   output logic [DATA_WIDTH-1:0] TX_DATA,
   output logic                  TX_VALID,
   input  logic                  TX_READY,
   output logic                  CMD_ERR,
   output logic                  RX_DROP
);

   localparam int unsigned CNT_W = $clog2(RES_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_ISSUE,
      S_WAIT_RES,
      S_SEND_LO,
      S_SEND_HI
   } state_e;

   state_e                state_q, state_d;
   logic [3:0]            fun_q, fun_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [OUT_WIDTH-1:0]  res_q, res_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  drop_q, drop_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         fun_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fun_q   <= fun_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fun_d    = fun_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      drop_d   = 1'b0;
      ALU_EN   = 1'b0;
      TX_VALID = 1'b0;
      TX_DATA  = '0;

      unique case (state_q)
         S_IDLE: begin
            if (RX_VALID) begin
               if (RX_DATA[DATA_WIDTH-1 -: 4] == 4'hC) begin
                  fun_d   = RX_DATA[3:0];
                  state_d = S_GET_A;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_GET_A: begin
            if (RX_VALID) begin
               a_d     = RX_DATA;
               state_d = S_GET_B;
            end
         end
         S_GET_B: begin
            if (RX_VALID) begin
               b_d     = RX_DATA;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            ALU_EN  = 1'b1;
            drop_d  = RX_VALID;
            cnt_d   = '0;
            state_d = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            drop_d = RX_VALID;
            // A result arriving on the last allowed cycle still wins over timeout.
            if (OUT_VALID) begin
               res_d   = ALU_OUT;
               state_d = S_SEND_LO;
            end else if (cnt_q == CNT_W'(RES_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SEND_LO: begin
            drop_d   = RX_VALID;
            TX_VALID = 1'b1;
            TX_DATA  = res_q[DATA_WIDTH-1:0];
            if (TX_READY) state_d = S_SEND_HI;
         end
         S_SEND_HI: begin
            drop_d   = RX_VALID;
            TX_VALID = 1'b1;
            TX_DATA  = res_q[OUT_WIDTH-1 -: DATA_WIDTH];
            if (TX_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ALU_FUN = fun_q;
   assign A       = a_q;
   assign B       = b_q;
   assign CMD_ERR = err_q;
   assign RX_DROP = drop_q;

endmodule
